// File: rtl/tinymoa_cnt_sched.sv
// Round-robin scheduler sharing one up/down counter among NREQ requesters.
// Define TINYMOA_CNT_SCHED_SAT_EN for saturating counts (wrap then flags blocked steps).
module tinymoa_cnt_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_arg,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         grant,
  output logic [WIDTH-1:0]        count,
  output logic                    busy,
  output logic                    done,
  output logic                    wrap
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_UP = 2'b00, OP_DOWN = 2'b01, OP_LOAD = 2'b10, OP_CLEAR = 2'b11} op_t;

  state_t            state;
  op_t               op_r;
  logic [WIDTH-1:0]  rem_r;
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  gidx;

  logic [PTR_W-1:0]  win_idx;
  logic [NREQ-1:0]   win_oh;
  op_t               win_op;
  logic [WIDTH-1:0]  win_arg;
  logic [WIDTH-1:0]  step_cnt;
  logic              step_hit;

  // Lowest requester at or above ptr wins; otherwise lowest below ptr.
  always_comb begin
    win_idx = '0;
    win_oh  = '0;
    win_op  = OP_UP;
    win_arg = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (PTR_W'(i) < ptr)) begin
        win_idx    = PTR_W'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
        win_op     = op_t'(req_op[2*i +: 2]);
        win_arg    = req_arg[WIDTH*i +: WIDTH];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i] && (PTR_W'(i) >= ptr)) begin
        win_idx    = PTR_W'(i);
        win_oh     = '0;
        win_oh[i]  = 1'b1;
        win_op     = op_t'(req_op[2*i +: 2]);
        win_arg    = req_arg[WIDTH*i +: WIDTH];
      end
    end
  end

  // One burst step; step_hit marks a boundary crossing (or a blocked step when saturating).
  always_comb begin
    step_cnt = count;
    step_hit = 1'b0;
    if (op_r == OP_UP) begin
      if (count == CNT_MAX) begin
`ifdef TINYMOA_CNT_SCHED_SAT_EN
        step_hit = 1'b1;
`else
        step_hit = 1'b1;
        step_cnt = '0;
`endif
      end else begin
        step_cnt = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
`ifdef TINYMOA_CNT_SCHED_SAT_EN
        step_hit = 1'b1;
`else
        step_hit = 1'b1;
        step_cnt = CNT_MAX;
`endif
      end else begin
        step_cnt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_r      <= OP_UP;
      rem_r     <= '0;
      ptr       <= '0;
      gidx      <= '0;
      count     <= '0;
      grant     <= '0;
      req_ready <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      req_ready <= '0;
      done      <= 1'b0;
      wrap      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            gidx  <= win_idx;
            grant <= win_oh;
            op_r  <= win_op;
            rem_r <= win_arg;
            busy  <= 1'b1;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if ((op_r == OP_UP) || (op_r == OP_DOWN)) begin
            if (rem_r != '0) begin
              count <= step_cnt;
              wrap  <= step_hit;
              rem_r <= rem_r - WIDTH'(1);
            end
            if (rem_r <= WIDTH'(1)) begin
              req_ready <= grant;
              done      <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            count     <= (op_r == OP_LOAD) ? rem_r : '0;
            req_ready <= grant;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          ptr   <= (gidx == PTR_W'(NREQ - 1)) ? '0 : gidx + PTR_W'(1);
          grant <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tinymoa_cnt_sched.sv
// Directed bench for tinymoa_cnt_sched with a scoreboard of expected op completions.
// Honours TINYMOA_CNT_SCHED_SAT_EN in its reference model.
module tb_tinymoa_cnt_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [2*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_arg;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       grant;
  logic [WIDTH-1:0]      count;
  logic                  busy;
  logic                  done;
  logic                  wrap;

  typedef struct {
    int               r;
    logic [WIDTH-1:0] cnt;
    int               wraps;
    int               lat;
  } exp_t;

  exp_t             sb[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic [WIDTH-1:0] cur   = '0;

  tinymoa_cnt_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_arg   (req_arg),
    .req_ready (req_ready),
    .grant     (grant),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: counter value and boundary-event count after n clocked steps of an op.
  task automatic model(input logic [WIDTH-1:0] start, input logic [1:0] op,
                       input logic [WIDTH-1:0] arg, input int n,
                       output logic [WIDTH-1:0] c, output int w);
    c = start;
    w = 0;
    if (op == 2'b10) begin
      if (n >= 1) c = arg;
    end else if (op == 2'b11) begin
      if (n >= 1) c = '0;
    end else begin
      for (int s = 0; s < n && s < int'(arg); s++) begin
        if (op == 2'b00) begin
          if (c == {WIDTH{1'b1}}) begin
            w++;
`ifdef TINYMOA_CNT_SCHED_SAT_EN
            c = c;
`else
            c = '0;
`endif
          end else c = c + 1'b1;
        end else begin
          if (c == '0) begin
            w++;
`ifdef TINYMOA_CNT_SCHED_SAT_EN
            c = c;
`else
            c = {WIDTH{1'b1}};
`endif
          end else c = c - 1'b1;
        end
      end
    end
  endtask

  // Issue one op from requester r and follow it cycle by cycle to its ack.
  task automatic run_op(input int r, input logic [1:0] op, input logic [WIDTH-1:0] arg, input bit drop);
    exp_t             e;
    exp_t             got;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] ec;
    int               ew;
    int               wr;
    int               cyc;
    bit               seen;
    start   = cur;
    e.r     = r;
    model(start, op, arg, 1000, e.cnt, e.wraps);
    e.lat   = (op[1] == 1'b0 && arg != '0) ? int'(arg) + 1 : 2;
    sb.push_back(e);
    @(negedge clk);
    req_valid[r]              = 1'b1;
    req_op[2*r +: 2]          = op;
    req_arg[WIDTH*r +: WIDTH] = arg;
    wr   = 0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (wrap === 1'b1) wr++;
      model(start, op, arg, cyc - 1, ec, ew);
      chk("count_trace", 32'(count), 32'(ec));
      chk("wrap_total", 32'(wr), 32'(ew));
      chk("grant_hold", 32'(grant), 32'(1) << r);
      chk("busy_hold", 32'(busy), 32'd1);
      if (done === 1'b1) begin
        seen = 1'b1;
        got  = sb.pop_front();
        chk("ready_owner", 32'(req_ready), 32'(1) << got.r);
        chk("latency", 32'(cyc), 32'(got.lat));
        chk("final_count", 32'(count), 32'(got.cnt));
        chk("final_wraps", 32'(wr), 32'(got.wraps));
        req_valid[r] = 1'b0;
      end else begin
        chk("ready_quiet", 32'(req_ready), 32'd0);
      end
      if (cyc == 1 && drop) begin
        req_valid[r]              = 1'b0;
        req_arg[WIDTH*r +: WIDTH] = ~arg;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    cur = e.cnt;
  endtask

  initial begin
    exp_t e;
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_arg   = '0;
    repeat (2) @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;

    // Round robin: everyone requests clear and keeps valid up
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      e.r = k % 4; e.cnt = '0; e.wraps = 0; e.lat = 2;
      sb.push_back(e);
    end
    req_valid = '1;
    req_op    = '1;
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      @(negedge clk);
      chk("rr_grant", 32'(grant), 32'(1) << e.r);
      chk("rr_busy", 32'(busy), 32'd1);
      chk("rr_early_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("rr_done", 32'(done), 32'd1);
      chk("rr_ready", 32'(req_ready), 32'(1) << e.r);
      if (k == 4) req_valid = '0;
      @(negedge clk);
      chk("rr_gap_grant", 32'(grant), 32'd0);
      chk("rr_gap_busy", 32'(busy), 32'd0);
    end
    chk("rr_count", 32'(count), 32'd0);
    req_op = '0;
    cur    = '0;

    run_op(0, 2'b00, 8'd5, 1'b0);
    run_op(2, 2'b00, 8'd0, 1'b0);
    run_op(1, 2'b10, 8'd254, 1'b0);
    run_op(3, 2'b00, 8'd3, 1'b0);
    run_op(1, 2'b01, 8'd4, 1'b1);
    run_op(2, 2'b10, 8'h10, 1'b0);
    run_op(0, 2'b01, 8'd16, 1'b0);

    // Asynchronous reset in the middle of a long burst
    @(negedge clk);
    req_valid[3]   = 1'b1;
    req_op[7:6]    = 2'b00;
    req_arg[31:24] = 8'd20;
    repeat (5) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'd0);
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    req_valid = '0;
    req_op    = '0;
    req_arg   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cur   = '0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // Pointer restarts at 0: requesters 0 and 3 contend, 0 must win
    req_valid = 4'b1001;
    req_op    = '1;
    @(negedge clk);
    chk("ptr_rst_grant", 32'(grant), 32'd1);
    @(negedge clk);
    chk("ptr_rst_ready", 32'(req_ready), 32'd1);
    req_valid = '0;
    req_op    = '0;
    run_op(1, 2'b00, 8'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
